// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch PC register, next-PC mux and return-address stack.
// Optional macro PC_ERR_CLR_EN adds err_clr to clear the sticky error flags.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   stall         hold all state this cycle
//   err_clr       (PC_ERR_CLR_EN only) clear sticky error flags
//   op            000 SEQ, 001 BR, 010 JMP, 011 CALL, 100 RET, others SEQ
//   cond          branch-taken qualifier for BR
//   offset        signed relative offset for BR
//   target        absolute address for JMP/CALL
//   pc            registered fetch address
//   pc_next       value pc takes at the next unstalled edge
//   stack_empty   return stack holds no entries
//   stack_full    return stack holds STACK_DEPTH entries
//   overflow_err  sticky: CALL attempted with stack full
//   underflow_err sticky: RET attempted with stack empty
module program_counter_stack #(
    parameter int                    PC_WIDTH     = 8,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
`ifdef PC_ERR_CLR_EN
    input  logic                err_clr,
`endif
    input  logic [2:0]          op,
    input  logic                cond,
    input  logic [PC_WIDTH-1:0] offset,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                overflow_err,
    output logic                underflow_err
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [CW-1:0]       count;

    logic [PC_WIDTH-1:0] inc;
    logic [PC_WIDTH-1:0] br_dest;
    logic [PC_WIDTH-1:0] top;
    logic [IW-1:0]       top_idx;
    logic [IW-1:0]       push_idx;

    logic is_br;
    logic is_jmp;
    logic is_call;
    logic is_ret;

    logic do_push;
    logic do_pop;
    logic set_ovf;
    logic set_unf;

    assign stack_empty = (count == '0);
    assign stack_full  = (count == CW'(STACK_DEPTH));

    // Both adds are at PC width, so the sign extension of offset and
    // the modulo wrap come for free from two's-complement truncation.
    assign inc     = pc + PC_WIDTH'(1);
    assign br_dest = inc + offset;

    assign top_idx  = IW'(count - CW'(1));
    assign push_idx = IW'(count);
    assign top      = stack_mem[top_idx];

    assign is_br   = (op == OP_BR);
    assign is_jmp  = (op == OP_JMP);
    assign is_call = (op == OP_CALL);
    assign is_ret  = (op == OP_RET);

    always_comb begin
        pc_next = inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        unique case (1'b1)
            is_br: begin
                if (cond) pc_next = br_dest;
            end
            is_jmp: begin
                pc_next = target;
            end
            is_call: begin
                if (!stack_full) begin
                    pc_next = target;
                    do_push = 1'b1;
                end else begin
                    set_ovf = 1'b1;
                end
            end
            is_ret: begin
                if (!stack_empty) begin
                    pc_next = top;
                    do_pop  = 1'b1;
                end else begin
                    set_unf = 1'b1;
                end
            end
            default: begin
                pc_next = inc;
            end
        endcase
    end

    // Stack entries carry no reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (!rst && !stall && do_push) begin
            stack_mem[push_idx] <= inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
`ifdef PC_ERR_CLR_EN
            // Clear acts even while stalled; a same-cycle set below wins.
            if (err_clr) begin
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end
`endif
            if (!stall) begin
                pc <= pc_next;
                if (do_push) count <= count + CW'(1);
                if (do_pop)  count <= count - CW'(1);
                if (set_ovf) overflow_err  <= 1'b1;
                if (set_unf) underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack: directed vectors with a queued scoreboard.
// A monitor pops each expectation and checks pc_next, then post-edge state.
module tb_program_counter_stack;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       err_clr;
    logic [2:0] op;
    logic       cond;
    logic [7:0] offset;
    logic [7:0] target;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic       stack_empty;
    logic       stack_full;
    logic       overflow_err;
    logic       underflow_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       chkn;
        logic [7:0] en;
        logic [11:0] es;
    } exp_t;

    exp_t q[$];
    exp_t it;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] BR   = 3'b001;
    localparam logic [2:0] JMP  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;
    localparam logic [2:0] RSV  = 3'b111;

    program_counter_stack #(
        .PC_WIDTH    (8),
        .STACK_DEPTH (4),
        .RESET_VECTOR(8'h10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
`ifdef PC_ERR_CLR_EN
        .err_clr      (err_clr),
`endif
        .op           (op),
        .cond         (cond),
        .offset       (offset),
        .target       (target),
        .pc           (pc),
        .pc_next      (pc_next),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: inputs are stable at negedge, registers settle after posedge.
    always begin
        @(negedge clk);
        if (q.size() > 0) begin
            it = q.pop_front();
            if (it.chkn) chk({it.name, ".pc_next"}, {4'h0, pc_next}, {4'h0, it.en});
            @(posedge clk);
            #1;
            chk({it.name, ".state"},
                {pc, stack_empty, stack_full, overflow_err, underflow_err},
                it.es);
        end
    end

    // fl = {empty, full, ovf, unf} expected after the edge
    task automatic vec(input string nm, input logic r, input logic s,
                       input logic clr, input logic [2:0] o, input logic c,
                       input logic [7:0] off, input logic [7:0] tgt,
                       input logic chkn, input logic [7:0] en,
                       input logic [7:0] ep, input logic [3:0] fl);
        exp_t e;
        rst     = r;
        stall   = s;
        err_clr = clr;
        op      = o;
        cond    = c;
        offset  = off;
        target  = tgt;
        e.name  = nm;
        e.chkn  = chkn;
        e.en    = en;
        e.es    = {ep, fl};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset and sequential
        vec("rst",    1, 0, 0, SEQ, 0, 8'h00, 8'h00, 0, 8'h00, 8'h10, 4'b1000);
        vec("seq1",   0, 0, 0, SEQ, 0, 8'h00, 8'h00, 1, 8'h11, 8'h11, 4'b1000);
        vec("seq2",   0, 0, 0, SEQ, 0, 8'h00, 8'h00, 1, 8'h12, 8'h12, 4'b1000);
        vec("seq3",   0, 0, 0, RSV, 0, 8'h00, 8'h00, 1, 8'h13, 8'h13, 4'b1000);
        // branches and wrap
        vec("jmp20",  0, 0, 0, JMP, 0, 8'h00, 8'h20, 1, 8'h20, 8'h20, 4'b1000);
        vec("br_t",   0, 0, 0, BR,  1, 8'hFD, 8'h00, 1, 8'h1E, 8'h1E, 4'b1000);
        vec("br_nt",  0, 0, 0, BR,  0, 8'h05, 8'h00, 1, 8'h1F, 8'h1F, 4'b1000);
        vec("jmpff",  0, 0, 0, JMP, 0, 8'h00, 8'hFF, 1, 8'hFF, 8'hFF, 4'b1000);
        vec("wrap",   0, 0, 0, SEQ, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 4'b1000);
        vec("jmp02",  0, 0, 0, JMP, 0, 8'h00, 8'h02, 1, 8'h02, 8'h02, 4'b1000);
        vec("br_wr",  0, 0, 0, BR,  1, 8'hFC, 8'h00, 1, 8'hFF, 8'hFF, 4'b1000);
        vec("jmp00",  0, 0, 0, JMP, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 4'b1000);
        // nested calls, overflow, returns
        vec("call40", 0, 0, 0, CALL, 0, 8'h00, 8'h40, 1, 8'h40, 8'h40, 4'b0000);
        vec("call50", 0, 0, 0, CALL, 0, 8'h00, 8'h50, 1, 8'h50, 8'h50, 4'b0000);
        vec("call60", 0, 0, 0, CALL, 0, 8'h00, 8'h60, 1, 8'h60, 8'h60, 4'b0000);
        vec("call70", 0, 0, 0, CALL, 0, 8'h00, 8'h70, 1, 8'h70, 8'h70, 4'b0100);
        vec("call80", 0, 0, 0, CALL, 0, 8'h00, 8'h80, 1, 8'h71, 8'h71, 4'b0110);
        vec("ret1",   0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h61, 8'h61, 4'b0010);
        vec("ret2",   0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h51, 8'h51, 4'b0010);
        vec("ret3",   0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h41, 8'h41, 4'b0010);
        vec("ret4",   0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h01, 8'h01, 4'b1010);
        // underflow is sticky until reset
        vec("rst2",   1, 0, 0, SEQ, 0, 8'h00, 8'h00, 1, 8'h02, 8'h10, 4'b1000);
        vec("jmp05",  0, 0, 0, JMP, 0, 8'h00, 8'h05, 1, 8'h05, 8'h05, 4'b1000);
        vec("ret_e",  0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h06, 8'h06, 4'b1001);
        for (int i = 0; i < 5; i++) begin
            vec("stick", 0, 0, 0, SEQ, 0, 8'h00, 8'h00, 1,
                8'(8'h07 + i), 8'(8'h07 + i), 4'b1001);
        end
        vec("rst3",   1, 0, 0, SEQ, 0, 8'h00, 8'h00, 1, 8'h0C, 8'h10, 4'b1000);
        // stall holds everything while pc_next tracks op
        vec("jmp30",  0, 0, 0, JMP, 0, 8'h00, 8'h30, 1, 8'h30, 8'h30, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            vec("stall", 0, 1, 0, CALL, 0, 8'h00, 8'hAA, 1, 8'hAA, 8'h30, 4'b1000);
        end
        vec("callaa", 0, 0, 0, CALL, 0, 8'h00, 8'hAA, 1, 8'hAA, 8'hAA, 4'b0000);
        vec("ret31",  0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h31, 8'h31, 4'b1000);
        vec("st_ret", 0, 1, 0, RET, 0, 8'h00, 8'h00, 1, 8'h32, 8'h31, 4'b1000);
`ifdef PC_ERR_CLR_EN
        vec("u_set",  0, 0, 0, RET, 0, 8'h00, 8'h00, 1, 8'h32, 8'h32, 4'b1001);
        vec("u_clr",  0, 0, 1, SEQ, 0, 8'h00, 8'h00, 1, 8'h33, 8'h33, 4'b1000);
        vec("u_win",  0, 0, 1, RET, 0, 8'h00, 8'h00, 1, 8'h34, 8'h34, 4'b1001);
        vec("st_clr", 0, 1, 1, SEQ, 0, 8'h00, 8'h00, 1, 8'h35, 8'h34, 4'b1000);
`endif
        rst     = 1'b0;
        stall   = 1'b1;
        err_clr = 1'b0;
        op      = SEQ;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the fetch-stage program counter.
- Holds the PC register and computes the next PC for these sources: sequential, conditional relative branch, absolute jump, call and return.
- Includes a hardware return-address stack and a stall input.
- Sits between the decode/branch logic and instruction memory; drives the fetch address every cycle.

Parameters:
- PC_WIDTH, 8: width of pc, target, offset and stack entries.
- STACK_DEPTH, 4: number of return-address entries (>=1).
- RESET_VECTOR, 0: PC value loaded by reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  when 1, hold all state this cycle.
- op  input  3  PC operation:
  - 000 SEQ
  - 001 BR
  - 010 JMP
  - 011 CALL
  - 100 RET
  - 101-111 reserved, decoded as SEQ
- cond  input  1  branch-taken qualifier for BR only.
- offset  input  PC_WIDTH  signed two's-complement relative offset for BR.
- target  input  PC_WIDTH  absolute address for JMP/CALL.
- pc  output  PC_WIDTH  current fetch address (registered).
- pc_next  output  PC_WIDTH  combinational value pc will take at the next edge if not stalled.
- stack_empty  output  1  return stack holds 0 entries.
- stack_full  output  1  return stack holds STACK_DEPTH entries.
- overflow_err  output  1  sticky; a CALL was attempted with the stack full.
- underflow_err  output  1  sticky; a RET was attempted with the stack empty.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - pc = RESET_VECTOR
  - stack count = 0 (stack_empty=1, stack_full=0)
  - overflow_err = 0, underflow_err = 0
  - stack entry contents are don't-care
- rst has priority over stall and op.
- Arithmetic:
  - inc = pc + 1, modulo 2^PC_WIDTH.
  - BR taken: pc + 1 + offset, offset sign-extended, result modulo 2^PC_WIDTH.
  - Wrap-around is silent, e.g. 8'hFF + 1 = 8'h00, and 8'h02 + 1 + 8'hFC = 8'hFF.
- pc_next by op:
  - SEQ: inc.
  - BR: cond=1 gives inc+offset; cond=0 gives inc.
  - JMP: target.
  - CALL, stack not full: target, and inc is pushed.
  - CALL, stack full: inc. No push; overflow_err set.
  - RET, stack not empty: top of stack, which is popped.
  - RET, stack empty: inc. No pop; underflow_err set.
- Update at rising clk when rst=0 and stall=0: pc <= pc_next, stack push/pop as above, error flags set as above.
- stall=1: pc, stack contents, count and error flags all hold. pc_next still reflects the current op (observability only).
- Latency: pc changes one cycle after op is presented unstalled. pc_next is valid in the same cycle (zero latency).
- Stack is LIFO, count 0..STACK_DEPTH. stack_empty and stack_full are derived from the registered count and update in the same edge as the push/pop.
- Error flags are sticky until rst (see Optional Feature).
- Mid-operation rst discards all stack contents; a following RET underflows.
- No state machine beyond the PC register and the stack count. No handshake beyond stall.

Optional Feature:
- Macro: PC_ERR_CLR_EN
- Defined:
  - Adds input port err_clr (1 bit, after stall).
  - err_clr=1 at an unstalled or stalled edge clears overflow_err and underflow_err.
  - If a new error occurs in the same cycle, the set wins and the flag reads 1.
- Undefined: no err_clr port; flags clear only on rst.

Test Plan:
1. rst=1 for 1 cycle with RESET_VECTOR=8'h10, then 3 cycles op=SEQ -> pc = 10, 11, 12, 13; stack_empty=1; both errors 0.
2. pc=8'h20, op=BR, offset=8'hFD:
   - cond=1 -> next pc=8'h1E.
   - Then op=BR, cond=0, offset=8'h05 -> pc=8'h1F.
   - Then pc=8'hFF, op=SEQ -> pc=8'h00.
3. Nested calls from pc=8'h00:
   - CALL 8'h40, CALL 8'h50, CALL 8'h60, CALL 8'h70 -> stack_full=1.
   - Fifth CALL 8'h80 from pc=8'h70 -> pc=8'h71, overflow_err=1, no push.
   - Four RETs -> pc = 8'h61, 51, 41, 01.
   - stack_empty=1.
4. RET with empty stack at pc=8'h05 -> pc=8'h06, underflow_err=1. It stays 1 through 5 further SEQ cycles and clears only after rst.
5. stall=1 for 3 cycles with op=CALL, target=8'hAA at pc=8'h30 -> pc stays 8'h30, stack count unchanged, pc_next=8'hAA. Release stall -> pc=8'hAA, stack top=8'h31.
6. PC_ERR_CLR_EN defined:
   - Set underflow_err; then err_clr=1 with op=SEQ -> underflow_err=0.
   - err_clr=1 together with RET on empty -> underflow_err=1.
